// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: IF/ID stall, flush and ID/EX bubble control for load-use,
// branch/jump redirect and instruction-memory wait hazards, plus saturating counters.
//
// state        | meaning
// ST_RUN       | normal issue; load-use, redirect and imem readiness all evaluated
// ST_LU_STALL  | cycle after a load-use bubble; behaves as RUN with load-use masked
// ST_IMEM_WAIT | fetch outstanding; IF/ID flushed until imem_ready_in returns
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int WAIT_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             enable,
  input  logic [4:0]       IF_ID_Rs_in,
  input  logic [4:0]       IF_ID_Rt_in,
  input  logic             ID_EX_MemRead_in,
  input  logic [4:0]       ID_EX_Rt_in,
  input  logic             redirect_in,
  input  logic             imem_ready_in,
  output logic             PC_write_out,
  output logic             IF_ID_enable_out,
  output logic             IF_ID_flush_out,
  output logic             ID_EX_bubble_out,
  output logic [CNT_W-1:0] stall_cnt_out,
  output logic [CNT_W-1:0] flush_cnt_out,
  output logic             imem_timeout_out
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_LU_STALL  = 2'd1;
  localparam logic [1:0] ST_IMEM_WAIT = 2'd2;

  localparam int                WAIT_W   = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              timeout_q, timeout_d;

  logic load_use;
  logic load_use_eff;
  logic redirect_taken;
  logic pc_write;
  logic ifid_en;
  logic ifid_flush;
  logic idex_bubble;

  // A load into $zero never creates a real dependency.
  assign load_use = ID_EX_MemRead_in && (ID_EX_Rt_in != 5'd0) &&
                    ((ID_EX_Rt_in == IF_ID_Rs_in) || (ID_EX_Rt_in == IF_ID_Rt_in));

  assign load_use_eff = load_use && (state_q == ST_RUN);

  always_comb begin
    state_d        = state_q;
    pc_write       = 1'b0;
    ifid_en        = 1'b0;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    redirect_taken = 1'b0;

    case (state_q)
      ST_RUN, ST_LU_STALL: begin
        if (load_use_eff) begin
          idex_bubble = 1'b1;
          state_d     = ST_LU_STALL;
        end else if (redirect_in) begin
          pc_write       = 1'b1;
          ifid_en        = 1'b1;
          ifid_flush     = 1'b1;
          redirect_taken = 1'b1;
          state_d        = imem_ready_in ? ST_RUN : ST_IMEM_WAIT;
        end else if (!imem_ready_in) begin
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          state_d    = ST_IMEM_WAIT;
        end else begin
          pc_write = 1'b1;
          ifid_en  = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_IMEM_WAIT: begin
        pc_write   = imem_ready_in;
        ifid_en    = 1'b1;
        ifid_flush = !imem_ready_in;
        state_d    = imem_ready_in ? ST_RUN : ST_IMEM_WAIT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // A frozen pipeline issues nothing and advances nothing.
    if (!enable) begin
      state_d        = state_q;
      pc_write       = 1'b0;
      ifid_en        = 1'b0;
      ifid_flush     = 1'b0;
      idex_bubble    = 1'b0;
      redirect_taken = 1'b0;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (enable) begin
      if ((state_q != ST_IMEM_WAIT) && (state_d == ST_IMEM_WAIT)) begin
        wait_cnt_d = '0;
      end else if ((state_q == ST_IMEM_WAIT) && !imem_ready_in && (wait_cnt_q != WAIT_MAX)) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if ((state_q == ST_IMEM_WAIT) && (wait_cnt_d == WAIT_MAX)) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (enable && !pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect_taken && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Gate with reset so the pipeline sees no enables while reset is held.
  assign PC_write_out     = reset_in & pc_write;
  assign IF_ID_enable_out = reset_in & ifid_en;
  assign IF_ID_flush_out  = reset_in & ifid_flush;
  assign ID_EX_bubble_out = reset_in & idex_bubble;
  assign stall_cnt_out    = stall_cnt_q;
  assign flush_cnt_out    = flush_cnt_q;
  assign imem_timeout_out = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed hazard scenarios followed by randomized traffic,
// all compared against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W   = 5;
  localparam int WT      = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_in = 1'b0;
  logic             enable = 1'b0;
  logic [4:0]       IF_ID_Rs_in = '0;
  logic [4:0]       IF_ID_Rt_in = '0;
  logic             ID_EX_MemRead_in = 1'b0;
  logic [4:0]       ID_EX_Rt_in = '0;
  logic             redirect_in = 1'b0;
  logic             imem_ready_in = 1'b1;
  logic             PC_write_out;
  logic             IF_ID_enable_out;
  logic             IF_ID_flush_out;
  logic             ID_EX_bubble_out;
  logic [CNT_W-1:0] stall_cnt_out;
  logic [CNT_W-1:0] flush_cnt_out;
  logic             imem_timeout_out;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .WAIT_TIMEOUT(WT)) dut (
    .clk              (clk),
    .reset_in         (reset_in),
    .enable           (enable),
    .IF_ID_Rs_in      (IF_ID_Rs_in),
    .IF_ID_Rt_in      (IF_ID_Rt_in),
    .ID_EX_MemRead_in (ID_EX_MemRead_in),
    .ID_EX_Rt_in      (ID_EX_Rt_in),
    .redirect_in      (redirect_in),
    .imem_ready_in    (imem_ready_in),
    .PC_write_out     (PC_write_out),
    .IF_ID_enable_out (IF_ID_enable_out),
    .IF_ID_flush_out  (IF_ID_flush_out),
    .ID_EX_bubble_out (ID_EX_bubble_out),
    .stall_cnt_out    (stall_cnt_out),
    .flush_cnt_out    (flush_cnt_out),
    .imem_timeout_out (imem_timeout_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: previous enabled cycle was a load-use bubble / fetch outstanding.
  bit m_stalled;
  bit m_waiting;
  bit m_timeout;
  int m_wait;
  int m_stall;
  int m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_stalled = 1'b0;
    m_waiting = 1'b0;
    m_timeout = 1'b0;
    m_wait    = 0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  function automatic bit lu_now();
    return ID_EX_MemRead_in && (ID_EX_Rt_in != 5'd0) &&
           ((ID_EX_Rt_in == IF_ID_Rs_in) || (ID_EX_Rt_in == IF_ID_Rt_in));
  endfunction

  // {PC_write, IF_ID_enable, flush, bubble}
  function automatic logic [3:0] exp_ctrl();
    if (!reset_in || !enable) return 4'b0000;
    if (m_waiting) return {imem_ready_in, 1'b1, !imem_ready_in, 1'b0};
    if (lu_now() && !m_stalled) return 4'b0001;
    if (redirect_in) return 4'b1110;
    if (!imem_ready_in) return 4'b0110;
    return 4'b1100;
  endfunction

  task automatic model_clock();
    logic [3:0] c;
    bit         lu_hit;
    c      = exp_ctrl();
    lu_hit = lu_now() && !m_stalled && !m_waiting;
    if (!reset_in || !enable) return;
    if (!c[3] && m_stall < CNT_MAX) m_stall++;
    if (!m_waiting && !lu_hit && redirect_in && m_flush < CNT_MAX) m_flush++;
    if (m_waiting) begin
      m_stalled = 1'b0;
      if (imem_ready_in) m_waiting = 1'b0;
      else begin
        if (m_wait < WT) m_wait++;
        if (m_wait == WT) m_timeout = 1'b1;
      end
    end else if (lu_hit) begin
      m_stalled = 1'b1;
    end else begin
      m_stalled = 1'b0;
      if (!imem_ready_in) begin
        m_waiting = 1'b1;
        m_wait    = 0;
      end
    end
  endtask

  task automatic set_in(input bit mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                        input logic [4:0] rt, input bit redir, input bit rdy);
    ID_EX_MemRead_in = mr;
    ID_EX_Rt_in      = ex_rt;
    IF_ID_Rs_in      = rs;
    IF_ID_Rt_in      = rt;
    redirect_in      = redir;
    imem_ready_in    = rdy;
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    check({tag, " ctrl"}, 32'({PC_write_out, IF_ID_enable_out, IF_ID_flush_out, ID_EX_bubble_out}),
          32'(exp_ctrl()));
    check({tag, " stall_cnt"}, 32'(stall_cnt_out), m_stall);
    check({tag, " flush_cnt"}, 32'(flush_cnt_out), m_flush);
    check({tag, " timeout"}, 32'(imem_timeout_out), 32'(m_timeout));
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    enable   = 1'b1;
    reset_in = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_in = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check("reset ctrl", 32'({PC_write_out, IF_ID_enable_out, IF_ID_flush_out, ID_EX_bubble_out}), 0);
    check("reset stall_cnt", 32'(stall_cnt_out), 0);
    check("reset flush_cnt", 32'(flush_cnt_out), 0);
    check("reset timeout", 32'(imem_timeout_out), 0);
    do_reset();

    // Load-use on Rs: one bubble, then the masked cycle issues normally.
    set_in(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b1);
    step("lu stall");
    step("lu masked");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step("lu after");
    check("lu stall total", 32'(stall_cnt_out), 1);

    do_reset();
    set_in(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b1);
    step("zero 1");
    step("zero 2");
    check("zero stall total", 32'(stall_cnt_out), 0);

    do_reset();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    step("redir");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step("redir after");
    check("redir flush total", 32'(flush_cnt_out), 1);

    do_reset();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("imem3 low");
    imem_ready_in = 1'b1;
    step("imem3 ready");
    step("imem3 run");
    check("imem3 stall total", 32'(stall_cnt_out), 3);
    check("imem3 timeout", 32'(imem_timeout_out), 0);

    do_reset();
    imem_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) step("imem10 low");
    check("timeout before 8th wait", 32'(imem_timeout_out), 0);
    step("imem10 low");
    check("timeout after 8th wait", 32'(imem_timeout_out), 1);
    step("imem10 low");
    imem_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) step("imem10 ready");
    check("timeout sticky", 32'(imem_timeout_out), 1);
    do_reset();
    check("timeout cleared", 32'(imem_timeout_out), 0);

    // Load-use and redirect together, with a freeze while in the stall.
    do_reset();
    set_in(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b1);
    step("lu+redir stall");
    enable = 1'b0;
    step("freeze 1");
    step("freeze 2");
    enable = 1'b1;
    step("lu+redir redirect");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step("lu+redir after");
    check("lu+redir flush total", 32'(flush_cnt_out), 1);
    check("lu+redir stall total", 32'(stall_cnt_out), 1);

    // Asynchronous reset in the middle of an imem wait.
    do_reset();
    imem_ready_in = 1'b0;
    step("pre-areset low");
    step("pre-areset low");
    #2;
    reset_in = 1'b0;
    #1;
    check("areset ctrl", 32'({PC_write_out, IF_ID_enable_out, IF_ID_flush_out, ID_EX_bubble_out}), 0);
    check("areset stall_cnt", 32'(stall_cnt_out), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_in = 1'b1;
    imem_ready_in = 1'b1;
    step("post-areset run");

    do_reset();
    imem_ready_in = 1'b0;
    for (int i = 0; i < 40; i++) step("sat low");
    check("stall saturates", 32'(stall_cnt_out), CNT_MAX);

    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_in = 1'b0;
        model_reset();
      end else begin
        reset_in = 1'b1;
      end
      enable = 1'($urandom_range(0, 9) != 0);
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
